// File: rtl/inference_sequencer.sv
// -----------------------------------------------------------------------------
// inference_sequencer
//
// Batch-inference control block. On an accepted start it walks an input memory
// from base_addr, issues one vector per word to the model, waits for the
// model's result and hands it to a downstream sink over valid/ready. A run ends
// at the all-ones sentinel in element 0 or after MAX_SAMPLES results (0 means
// no limit).
//
// Ports
//   clk, reset          sole clock (rising edge), synchronous active-high reset
//   start, base_addr    run request (ignored while busy) and first address
//   mem_addr, mem_data  combinational-read memory port
//   model_in_*          registered vector + one-cycle issue strobe to the model
//   model_out_*         model result and its valid strobe (honoured in WAIT only)
//   res_data/valid/ready  result handshake towards the sink
//   busy, done          run in progress / run finished (held until next start)
//   sample_count        results accepted downstream this run (saturating)
// -----------------------------------------------------------------------------
module inference_sequencer #(
    parameter int DATA_W      = 16,
    parameter int IN_DIM      = 4,
    parameter int OUT_DIM     = 2,
    parameter int ADDR_W      = 32,
    parameter int MAX_SAMPLES = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W*IN_DIM-1:0]  mem_data,
    output logic [DATA_W*IN_DIM-1:0]  model_in_data,
    output logic                      model_in_valid,
    input  logic [DATA_W*OUT_DIM-1:0] model_out_data,
    input  logic                      model_out_ready,
    output logic [DATA_W*OUT_DIM-1:0] res_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               sample_count
);

    localparam bit          LIMITED = (MAX_SAMPLES != 0);
    localparam logic [15:0] LIMIT   = 16'(MAX_SAMPLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [ADDR_W-1:0]           addr_reg, addr_next;
    logic [DATA_W*IN_DIM-1:0]    buf_reg, buf_next;
    logic [DATA_W*OUT_DIM-1:0]   res_reg, res_next;
    logic [15:0]                 count_reg, count_next;
    logic                        issue_reg, valid_reg, busy_reg, done_reg;
    logic                        is_sentinel;

    assign is_sentinel = (mem_data[DATA_W-1:0] == {DATA_W{1'b1}});

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        buf_next   = buf_reg;
        res_next   = res_reg;
        count_next = count_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_next  = base_addr;
                    count_next = 16'd0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // The word is captured even when it turns out to be the
                // sentinel; it is simply never issued.
                buf_next = mem_data;
                if (is_sentinel) begin
                    state_next = S_DONE;
                end else if (LIMITED && (count_reg == LIMIT)) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (model_out_ready) begin
                    res_next   = model_out_data;
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (res_ready) begin
                    if (count_reg != 16'hFFFF) begin
                        count_next = count_reg + 16'd1;
                    end
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = S_FETCH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status strobes are registered from the next state so they line up
    // exactly with the state they describe without any input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            addr_reg  <= '0;
            buf_reg   <= '0;
            res_reg   <= '0;
            count_reg <= '0;
            issue_reg <= 1'b0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            buf_reg   <= buf_next;
            res_reg   <= res_next;
            count_reg <= count_next;
            issue_reg <= (state_next == S_ISSUE);
            valid_reg <= (state_next == S_EMIT);
            busy_reg  <= (state_next == S_FETCH) || (state_next == S_ISSUE) ||
                         (state_next == S_WAIT)  || (state_next == S_EMIT);
            done_reg  <= (state_next == S_DONE);
        end
    end

    assign mem_addr       = addr_reg;
    assign model_in_data  = buf_reg;
    assign model_in_valid = issue_reg;
    assign res_data       = res_reg;
    assign res_valid      = valid_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign sample_count   = count_reg;

endmodule

// File: tb/tb_inference_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inference_sequencer
//
// Bench for inference_sequencer. A behavioural memory and model surround two
// instances: dut (unlimited) and dut_lim (MAX_SAMPLES = 2). Expected results
// are computed from the memory contents when each run is started and popped
// as the sink accepts results.
// -----------------------------------------------------------------------------
module tb_inference_sequencer;

    localparam int DW = 16;
    localparam int ID = 4;
    localparam int OD = 2;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [AW-1:0]     mem_addr;
    logic [DW*ID-1:0]  mem_data;
    logic [DW*ID-1:0]  model_in_data;
    logic              model_in_valid;
    logic [DW*OD-1:0]  model_out_data;
    logic              model_out_ready;
    logic [DW*OD-1:0]  res_data;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic [15:0]       sample_count;

    logic              lim_start;
    logic [AW-1:0]     lim_base;
    logic [AW-1:0]     lim_mem_addr;
    logic [DW*ID-1:0]  lim_mem_data;
    logic [DW*ID-1:0]  lim_in_data;
    logic              lim_in_valid;
    logic [DW*OD-1:0]  lim_out_data;
    logic              lim_out_ready;
    logic [DW*OD-1:0]  lim_res_data;
    logic              lim_res_valid;
    logic              lim_res_ready;
    logic              lim_busy;
    logic              lim_done;
    logic [15:0]       lim_count;

    logic [DW*ID-1:0]  mem [256];
    assign mem_data     = mem[mem_addr[7:0]];
    assign lim_mem_data = mem[lim_mem_addr[7:0]];

    inference_sequencer #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD), .ADDR_W(AW), .MAX_SAMPLES(0)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .model_in_data(model_in_data), .model_in_valid(model_in_valid),
        .model_out_data(model_out_data), .model_out_ready(model_out_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .done(done), .sample_count(sample_count)
    );

    inference_sequencer #(.DATA_W(DW), .IN_DIM(ID), .OUT_DIM(OD), .ADDR_W(AW), .MAX_SAMPLES(2)) dut_lim (
        .clk(clk), .reset(reset), .start(lim_start), .base_addr(lim_base),
        .mem_addr(lim_mem_addr), .mem_data(lim_mem_data),
        .model_in_data(lim_in_data), .model_in_valid(lim_in_valid),
        .model_out_data(lim_out_data), .model_out_ready(lim_out_ready),
        .res_data(lim_res_data), .res_valid(lim_res_valid), .res_ready(lim_res_ready),
        .busy(lim_busy), .done(lim_done), .sample_count(lim_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int issues   = 0;
    int lim_issues = 0;
    int lat      = 1;
    int spur     = 0;
    int stall    = 0;
    logic [DW*OD-1:0] exp_q [$];
    int acc_cyc [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model of the inference datapath.
    function automatic logic [DW*OD-1:0] fmod(input logic [DW*ID-1:0] v);
        logic [DW*OD-1:0] r;
        r[15:0]  = v[15:0] + v[31:16] + v[47:32] + v[63:48];
        r[31:16] = v[15:0] ^ v[63:48] ^ 16'h5A5A;
        return r;
    endfunction

    function automatic logic [DW*ID-1:0] mkvec(input int k);
        return {16'(k * 7 + 3), 16'(k * 5 + 2), 16'(k * 3 + 1), 16'(k + 256)};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (model_in_valid) issues++;
        if (lim_in_valid) lim_issues++;
    end

    // Model for the main instance: configurable latency, optional spurious
    // ready during the issue cycle.
    initial begin
        logic [DW*OD-1:0] d;
        model_out_ready = 1'b0;
        model_out_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (model_in_valid) begin
                d = fmod(model_in_data);
                if (spur != 0) begin
                    model_out_ready = 1'b1;
                    model_out_data  = 32'hDEAD_BEEF;
                    @(posedge clk); #1;
                    model_out_ready = 1'b0;
                    model_out_data  = '0;
                    repeat (lat - 1) @(posedge clk);
                    #1;
                end else begin
                    repeat (lat) @(posedge clk);
                    #1;
                end
                model_out_ready = 1'b1;
                model_out_data  = d;
                @(posedge clk); #1;
                model_out_ready = 1'b0;
            end
        end
    end

    // Model for the limited instance: fixed latency of one cycle.
    initial begin
        logic [DW*OD-1:0] d;
        lim_out_ready = 1'b0;
        lim_out_data  = '0;
        forever begin
            @(posedge clk); #1;
            lim_out_ready = 1'b0;
            if (lim_in_valid) begin
                d = fmod(lim_in_data);
                @(posedge clk); #1;
                lim_out_ready = 1'b1;
                lim_out_data  = d;
            end
        end
    end

    // Sink: holds ready low for 'stall' cycles of each result.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (res_valid) begin
                if (stall_cnt < stall) begin
                    res_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    res_ready = 1'b1;
                end
            end else begin
                stall_cnt = 0;
                res_ready = (stall == 0);
            end
        end
    end

    // Scoreboard: every valid cycle must show the oldest expected result.
    always @(negedge clk) begin
        if (!reset && res_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("res_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                check_eq("res_data", res_data, exp_q[0]);
                if (res_ready) begin
                    $display("accept: res_data=%08h sample_count=%0d cycle=%0d", res_data, sample_count, cyc);
                    void'(exp_q.pop_front());
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expected(input logic [AW-1:0] b);
        logic [AW-1:0] a;
        a = b;
        while (mem[a[7:0]][15:0] != 16'hFFFF) begin
            exp_q.push_back(fmod(mem[a[7:0]]));
            a = a + 1;
        end
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(negedge clk);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check_eq(tag, 64'(done), 64'd1);
    endtask

    initial begin
        int n0;
        int done_cyc;
        int k;
        for (int i = 0; i < 256; i++) mem[i] = '1;
        reset = 1'b1; start = 1'b0; base_addr = '0;
        lim_start = 1'b0; lim_base = '0; lim_res_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_in_data", model_in_data, 0);
        check_eq("rst_in_valid", model_in_valid, 0);
        check_eq("rst_res_data", res_data, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_count", sample_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Three vectors then sentinel, L=1, no stall
        for (int i = 0; i < 3; i++) mem[i] = mkvec(i + 1);
        lat = 1; stall = 0; acc_cyc.delete(); n0 = issues;
        push_expected(0);
        do_start(0);
        check_eq("t1_fetch_busy", busy, 1);
        check_eq("t1_fetch_addr", mem_addr, 0);
        wait_done("t1_done_timeout", 100);
        done_cyc = cyc;
        check_eq("t1_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            check_eq("t1_spacing0", acc_cyc[1] - acc_cyc[0], 4);
            check_eq("t1_spacing1", acc_cyc[2] - acc_cyc[1], 4);
            check_eq("t1_done_lat", done_cyc - acc_cyc[2], 2);
        end
        check_eq("t1_issues", issues - n0, 3);
        check_eq("t1_count", sample_count, 3);
        check_eq("t1_busy", busy, 0);
        check_eq("t1_addr", mem_addr, 3);
        check_eq("t1_queue", exp_q.size(), 0);

        // L=5 with a 3-cycle downstream stall per sample
        mem[8'h20] = mkvec(20); mem[8'h21] = mkvec(21);
        lat = 5; stall = 3; acc_cyc.delete();
        push_expected(32'h20);
        do_start(32'h20);
        wait_done("t2_done_timeout", 200);
        check_eq("t2_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check_eq("t2_period", acc_cyc[1] - acc_cyc[0], 11);
        check_eq("t2_count", sample_count, 2);
        check_eq("t2_queue", exp_q.size(), 0);
        stall = 0; lat = 1;
        repeat (2) @(negedge clk);

        // Sample limit of 2 with five valid vectors
        for (int i = 0; i < 5; i++) mem[8'h40 + i] = mkvec(40 + i);
        n0 = lim_issues;
        @(negedge clk); lim_base = 32'h40; lim_start = 1'b1;
        @(negedge clk); lim_start = 1'b0;
        k = 0;
        while (!lim_done && k < 100) begin @(negedge clk); k++; end
        check_eq("t3_done", lim_done, 1);
        check_eq("t3_issues", lim_issues - n0, 2);
        check_eq("t3_count", lim_count, 2);
        check_eq("t3_busy", lim_busy, 0);
        check_eq("t3_addr", lim_mem_addr, 32'h42);

        // Spurious model ready in the issue cycle, real one 3 cycles later
        mem[8'h50] = mkvec(50);
        lat = 3; spur = 1; acc_cyc.delete();
        push_expected(32'h50);
        do_start(32'h50);
        wait_done("t4_done_timeout", 100);
        check_eq("t4_accepts", acc_cyc.size(), 1);
        check_eq("t4_queue", exp_q.size(), 0);
        spur = 0;

        // Reset in WAIT, then a fresh run at 0x10
        mem[8'h60] = mkvec(60); mem[8'h10] = mkvec(10);
        lat = 4;
        push_expected(32'h60);
        do_start(32'h60);
        k = 0;
        while (!model_in_valid && k < 20) begin @(negedge clk); k++; end
        check_eq("t5_issue_seen", model_in_valid, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_eq("t5_mem_addr", mem_addr, 0);
        check_eq("t5_in_data", model_in_data, 0);
        check_eq("t5_in_valid", model_in_valid, 0);
        check_eq("t5_res_data", res_data, 0);
        check_eq("t5_res_valid", res_valid, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_done", done, 0);
        check_eq("t5_count", sample_count, 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        lat = 1; acc_cyc.delete();
        push_expected(32'h10);
        do_start(32'h10);
        check_eq("t5_fetch_addr", mem_addr, 32'h10);
        check_eq("t5_fetch_count", sample_count, 0);
        wait_done("t5_done_timeout", 100);
        check_eq("t5_final_count", sample_count, 1);
        check_eq("t5_queue", exp_q.size(), 0);

        // Address wrap, plus a start pulse while busy
        mem[8'hFF] = mkvec(99); mem[0] = '1;
        acc_cyc.delete();
        push_expected(32'hFFFF_FFFF);
        do_start(32'hFFFF_FFFF);
        @(negedge clk); base_addr = 32'h10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("t6_done_timeout", 100);
        check_eq("t6_count", sample_count, 1);
        check_eq("t6_addr", mem_addr, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_accepts", acc_cyc.size(), 1);
        check_eq("t6_queue", exp_q.size(), 0);
        repeat (4) @(negedge clk);
        check_eq("t6_done_held", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
